// File: rtl/sign_mag_display_pkg.sv
// rtl/sign_mag_display_pkg.sv - shared states, segment codes and BCD step helper for sign_mag_display
package sign_mag_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // One shift-add-3 step on {tens, ones, binary}: correct nibbles >= 5, then shift left
    function automatic logic [13:0] bcd_step(input logic [13:0] sr);
        logic [13:0] t;
        t = sr;
        if (t[9:6] >= 4'd5) begin
            t[9:6] = t[9:6] + 4'd3;
        end
        if (t[13:10] >= 4'd5) begin
            t[13:10] = t[13:10] + 4'd3;
        end
        return {t[12:0], 1'b0};
    endfunction

endpackage

// File: rtl/sign_mag_display_bcd_to_seven_seg.sv
// rtl/sign_mag_display_bcd_to_seven_seg.sv - combinational BCD digit to active-low seven-segment code
module bcd_to_seven_seg
    import sign_mag_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    // Blank wins over minus, minus wins over the numeric digit
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (minus) begin
            seg = SEG_MINUS;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sign_mag_display.sv
// rtl/sign_mag_display.sv - captures a sign/magnitude result, converts to BCD and scans it onto four digits
module sign_mag_display
    import sign_mag_display_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int MAG_W    = 6
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             resultValid,
    input  logic             resultSign,
    input  logic [MAG_W-1:0] resultMag,
    output logic             busy,
    output logic [6:0]       segments,
    output logic [3:0]       anodes
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t           state;
    logic [13:0]      sr;
    logic [2:0]       bit_cnt;
    logic             cap_sign;
    logic [3:0]       ones_r;
    logic [3:0]       tens_r;
    logic             sign_r;

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       scan_idx;

    logic [3:0]       ones_n;
    logic [3:0]       tens_n;
    logic             sign_n;
    logic [CNT_W-1:0] cnt_n;
    logic [1:0]       idx_n;
    logic [3:0]       dig_bcd;
    logic             dig_blank;
    logic             dig_minus;
    logic [6:0]       seg_n;
    logic [3:0]       anode_n;

    // Capture, six shift-add-3 steps, then load the displayed digits
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            cap_sign <= 1'b0;
            ones_r   <= '0;
            tens_r   <= '0;
            sign_r   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (resultValid) begin
                        sr       <= {8'd0, resultMag};
                        cap_sign <= resultSign;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr      <= bcd_step(sr);
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd5) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    ones_r <= sr[9:6];
                    tens_r <= sr[13:10];
                    sign_r <= cap_sign;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Look ahead at the digit values and scan position the registers are about to hold,
    // so the registered segment output shows a new result on the same edge it is loaded
    always_comb begin
        ones_n = ones_r;
        tens_n = tens_r;
        sign_n = sign_r;
        if (state == UPDATE) begin
            ones_n = sr[9:6];
            tens_n = sr[13:10];
            sign_n = cap_sign;
        end
        cnt_n = scan_cnt + CNT_W'(1);
        idx_n = scan_idx;
        if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt_n = '0;
            idx_n = scan_idx + 2'd1;
        end
        dig_bcd   = ones_n;
        dig_blank = 1'b0;
        dig_minus = 1'b0;
        case (idx_n)
            2'd0: begin
                dig_bcd = ones_n;
            end
            2'd1: begin
                dig_bcd   = tens_n;
                dig_blank = (tens_n == 4'd0);
            end
            2'd2: begin
                // Negative zero shows no minus sign
                dig_minus = sign_n && ((ones_n != 4'd0) || (tens_n != 4'd0));
                dig_blank = !dig_minus;
            end
            default: begin
                dig_blank = 1'b1;
            end
        endcase
        anode_n = ~(NUM_DIGITS'(1) << idx_n);
    end

    bcd_to_seven_seg u_seg (
        .bcd   (dig_bcd),
        .blank (dig_blank),
        .minus (dig_minus),
        .seg   (seg_n)
    );

    // Free-running digit scan with registered, glitch-free segment and anode drive
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            anodes   <= 4'b1110;
            segments <= SEG_0;
        end else begin
            scan_cnt <= cnt_n;
            scan_idx <= idx_n;
            anodes   <= anode_n;
            segments <= seg_n;
        end
    end

endmodule

// File: tb/tb_sign_mag_display.sv
// tb/tb_sign_mag_display.sv - scoreboard bench for sign_mag_display
module tb_sign_mag_display;

    localparam int SD = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       resultValid = 1'b0;
    logic       resultSign = 1'b0;
    logic [5:0] resultMag = 6'd0;
    logic       busy;
    logic [6:0] segments;
    logic [3:0] anodes;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    typedef struct {
        logic [6:0] d0;
        logic [6:0] d1;
        logic [6:0] d2;
        int         tag;
    } exp_t;

    exp_t q[$];

    sign_mag_display #(.SCAN_DIV(SD), .MAG_W(6)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .resultValid (resultValid),
        .resultSign  (resultSign),
        .resultMag   (resultMag),
        .busy        (busy),
        .segments    (segments),
        .anodes      (anodes)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(input logic s, input int m);
        exp_t e;
        e.d0  = seg_of(m % 10);
        e.d1  = (m / 10 == 0) ? SB : seg_of(m / 10);
        e.d2  = (s && m != 0) ? SM : SB;
        e.tag = s ? -m : m;
        if (s && m == 0) e.tag = 1000;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Collect one full scan period of segment patterns, starting at the current sample
    task automatic observe(output logic [6:0] d0, output logic [6:0] d1,
                           output logic [6:0] d2, output logic [6:0] d3);
        d0 = 7'h00; d1 = 7'h00; d2 = 7'h00; d3 = 7'h00;
        for (int i = 0; i < 4 * SD; i++) begin
            if (i > 0) @(negedge clk);
            case (anodes)
                4'b1110: d0 = segments;
                4'b1101: d1 = segments;
                4'b1011: d2 = segments;
                4'b0111: d3 = segments;
                default: ;
            endcase
        end
    endtask

    // Monitor: on each busy fall, check busy length and the newly displayed digits
    initial begin
        int         bcnt;
        logic       prev;
        exp_t       e;
        logic [6:0] a0, a1, a2, a3;
        bcnt = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                bcnt = 0;
                prev = 1'b0;
            end else if (busy) begin
                bcnt++;
                prev = 1'b1;
            end else if (prev) begin
                prev = 1'b0;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_update: got update with empty scoreboard");
                end else begin
                    e = q.pop_front();
                    check($sformatf("busy_len_%0d", e.tag), bcnt, 7);
                    observe(a0, a1, a2, a3);
                    check($sformatf("d0_%0d", e.tag), a0, e.d0);
                    check($sformatf("d1_%0d", e.tag), a1, e.d1);
                    check($sformatf("d2_%0d", e.tag), a2, e.d2);
                    check($sformatf("d3_%0d", e.tag), a3, SB);
                end
                bcnt = 0;
                done_cnt++;
            end
        end
    end

    task automatic capture(input logic s, input logic [5:0] m);
        @(negedge clk);
        resultValid = 1'b1;
        resultSign  = s;
        resultMag   = m;
        @(negedge clk);
        resultValid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            tests++;
            fails++;
            $display("FAIL timeout_wait_done: got %0d updates expected %0d", done_cnt, target);
        end
    endtask

    initial begin
        logic [6:0] b0, b1, b2, b3;
        int         idx;
        int         k;

        resetN = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_anodes", anodes, 4'b1110);
        check("rst_segments", segments, S0);

        resetN = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            idx = (n / SD) % 4;
            check($sformatf("idle_anodes_%0d", n), anodes, 4'(~(4'b0001 << idx)));
            check($sformatf("idle_seg_%0d", n), segments, (idx == 0) ? S0 : SB);
        end

        q.push_back('{S0, S3, SM, -30});
        capture(1'b1, 6'd30);
        wait_done(1);

        q.push_back('{S7, SB, SB, 7});
        capture(1'b0, 6'd7);
        wait_done(2);

        q.push_back('{S0, SB, SB, 1000});
        capture(1'b1, 6'd0);
        wait_done(3);

        // Second request during busy must be dropped
        q.push_back('{S3, S6, SB, 63});
        capture(1'b0, 6'd63);
        @(negedge clk);
        resultValid = 1'b1;
        resultMag   = 6'd5;
        @(negedge clk);
        resultValid = 1'b0;
        wait_done(4);

        // Reset mid-conversion: in-flight value discarded
        capture(1'b0, 6'd45);
        repeat (3) @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_anodes", anodes, 4'b1110);
        check("abort_segments", segments, S0);
        repeat (2) @(posedge clk);
        #3;
        resetN = 1'b1;
        @(negedge clk);
        observe(b0, b1, b2, b3);
        check("abort_d0", b0, S0);
        check("abort_d1", b1, SB);
        check("abort_d2", b2, SB);
        check("abort_d3", b3, SB);

        k = 4;
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 64; m++) begin
                q.push_back(model(s[0], m));
                capture(s[0], 6'(m));
                k++;
                wait_done(k);
            end
        end

        repeat (40) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);
        check("update_count", done_cnt, k);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sign_mag_display.md
SIGN_MAG_DISPLAY -- requirements
Module: sign_mag_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, clock cycles each digit stays lit (minimum 1).
REQ-002 SHALL have parameter MAG_W, default 6, magnitude width (fixed at 6 for this release).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port resultValid  input  1  one-cycle strobe: new result present.
REQ-006 SHALL have port resultSign  input  1  sign of result, 1 = negative.
REQ-007 SHALL have port resultMag  input  6  unsigned magnitude, 0..63.
REQ-008 SHALL have port busy  output  1  high while a capture is being converted.
REQ-009 SHALL have port segments  output  7  {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port anodes  output  4  one-hot digit enable, active-low.

Function
REQ-011 SHALL capture resultSign/resultMag on a rising edge where resultValid=1 and state=IDLE; resultValid in any other state SHALL be ignored (dropped, no queuing).
REQ-012 SHALL implement FSM IDLE -> CONVERT (exactly 6 cycles) -> UPDATE (1 cycle) -> IDLE.
REQ-013 CONVERT SHALL run shift-add-3 binary-to-BCD, one magnitude bit per cycle, MSB first: add 3 to any BCD nibble >= 5, then shift.
REQ-014 UPDATE SHALL load displayed ones, tens and sign registers from the conversion result in one edge.
REQ-015 busy SHALL be 1 in CONVERT and UPDATE, 0 in IDLE: high 7 cycles after the capture edge.
REQ-016 The new value SHALL appear on the display at the 7th edge after the capture edge, so latency is 7 cycles; the next capture is possible on that same edge's following cycle.
REQ-017 Digit 0 SHALL show ones; digit 1 tens, blanked when tens=0; digit 2 '-' when sign=1 and magnitude!=0, else blank; digit 3 always blank.
REQ-018 Negative zero (sign=1, mag=0) SHALL display as "0", no minus.
REQ-019 Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, blank=1111111.
REQ-020 A scan counter SHALL advance the digit index every SCAN_DIV cycles, 0->1->2->3->0 wrap; anodes SHALL be 1110,1101,1011,0111 for indexes 0..3.
REQ-021 Scanning SHALL run continuously, independent of FSM state; the display SHALL keep the previous value during CONVERT.
REQ-022 segments and anodes SHALL be registered (change only on clk edges, glitch-free).

Reset
REQ-023 resetN low SHALL asynchronously force: state=IDLE, busy=0, ones=0, tens=0, sign=0, scan index=0, scan counter=0, anodes=1110, segments=1000000.
REQ-024 Reset during CONVERT/UPDATE SHALL abort the conversion; the display returns to "0" and the in-flight value is discarded.
REQ-025 After resetN deasserts, a capture SHALL be accepted on the first edge with resultValid=1.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE, CONVERT, UPDATE), the segment constants for digits 0-9, minus and blank, and NUM_DIGITS=4.
REQ-027 Digit-to-segment mapping SHALL be a combinational sub-module bcd_to_seven_seg (4-bit BCD in, plus blank and minus selects, 7-bit segments out).

Verification
REQ-028 Reset then idle: anodes cycle 1110/1101/1011/0111 every SCAN_DIV cycles; digit0 segments=1000000, others 1111111.
REQ-029 Capture sign=1, mag=30 -> busy high exactly 7 cycles; then digit0=1000000 ('0'), digit1=0110000 ('3'), digit2=0111111 ('-').
REQ-030 Capture sign=0, mag=7 -> digit0=1111000, digit1 blank, digit2 blank; sign=1, mag=0 -> displays "0", no minus.
REQ-031 Capture mag=63, then pulse resultValid with mag=5 on cycle 3 of busy -> second request ignored; display shows "63".
REQ-032 Assert resetN low on cycle 4 of CONVERT after a capture with mag=45 -> all outputs at reset values immediately; after release the display shows "0".
REQ-033 Sweep mag 0..63 with both signs -> displayed tens/ones match the decimal value for every input.
